// File: rtl/pedal_frame_sequencer.sv
// pedal_frame_sequencer
//
// Frame-level controller for a single-sample START/DONE effect datapath.
// A frame of FRAME_LEN samples is collected from the ADC stream, every
// sample is handed to the effect with a full four-phase handshake, the
// saturated result is written back in place, and the processed frame is
// streamed out to the DAC path.
//
// Ports:
//   CLK, RESET_N        rising-edge clock, asynchronous active-low reset
//   ENABLE              run frames (sampled in IDLE and at frame end)
//   GAIN_SEL            gain config, latched onto EFF_GAIN at each frame start
//   IN_VALID/IN_READY   input sample stream (IN_READY high only while filling)
//   IN_SAMPLE           signed 16-bit input sample
//   EFF_START/EFF_DONE  effect handshake, START held until DONE is seen
//   EFF_GAIN, EFF_IN    latched gain and sample presented to the effect
//   EFF_OUT             signed EFF_W-bit effect result
//   OUT_VALID/OUT_READY output sample stream
//   OUT_SAMPLE          signed 16-bit processed sample
//   BUSY                controller is not idle
//   FRAME_DONE          one-cycle pulse after the last output handshake
//   TIMEOUT_ERR         sticky flag, set when the effect misses its deadline

module pedal_frame_sequencer #(
  parameter int FRAME_LEN = 1000,
  parameter int ADDR_W    = 10,
  parameter int EFF_W     = 18,
  parameter int TIMEOUT   = 15
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    ENABLE,
  input  logic                    GAIN_SEL,
  input  logic                    IN_VALID,
  input  logic signed [15:0]      IN_SAMPLE,
  output logic                    IN_READY,
  output logic                    EFF_START,
  output logic                    EFF_GAIN,
  output logic signed [15:0]      EFF_IN,
  input  logic                    EFF_DONE,
  input  logic signed [EFF_W-1:0] EFF_OUT,
  output logic                    OUT_VALID,
  output logic signed [15:0]      OUT_SAMPLE,
  input  logic                    OUT_READY,
  output logic                    BUSY,
  output logic                    FRAME_DONE,
  output logic                    TIMEOUT_ERR
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic signed [EFF_W-1:0] SAT_MAX = EFF_W'(32767);
  localparam logic signed [EFF_W-1:0] SAT_MIN = EFF_W'(-32768);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   next_idx;
  logic [WAIT_W-1:0]   wait_cnt;
  logic signed [15:0]  frame_buf [FRAME_LEN];

  assign next_idx = idx + 1'b1;

  // Clamp the wide effect result into the 16-bit sample range.
  function automatic logic signed [15:0] sat16(input logic signed [EFF_W-1:0] v);
    if (v > SAT_MAX) begin
      return 16'sh7FFF;
    end else if (v < SAT_MIN) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

  // Frame buffer has no reset; its contents are only read after being written
  // in the current frame. A timed-out sample is simply not overwritten, which
  // is what lets it pass through unchanged.
  always_ff @(posedge CLK) begin
    if (state == ST_FILL && IN_VALID && IN_READY) begin
      frame_buf[idx] <= IN_SAMPLE;
    end else if (state == ST_WAIT && EFF_DONE) begin
      frame_buf[idx] <= sat16(EFF_OUT);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      IN_READY    <= 1'b0;
      EFF_START   <= 1'b0;
      EFF_GAIN    <= 1'b0;
      EFF_IN      <= '0;
      OUT_VALID   <= 1'b0;
      OUT_SAMPLE  <= '0;
      BUSY        <= 1'b0;
      FRAME_DONE  <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ENABLE) begin
            EFF_GAIN <= GAIN_SEL;
            idx      <= '0;
            IN_READY <= 1'b1;
            BUSY     <= 1'b1;
            state    <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (IN_VALID && IN_READY) begin
            if (idx == LAST_IDX) begin
              idx      <= '0;
              IN_READY <= 1'b0;
              state    <= ST_ISSUE;
            end else begin
              idx <= next_idx;
            end
          end
        end

        ST_ISSUE: begin
          EFF_IN    <= frame_buf[idx];
          EFF_START <= 1'b1;
          wait_cnt  <= '0;
          state     <= ST_WAIT;
        end

        // DONE is tested before the deadline so a DONE arriving on the last
        // allowed cycle still counts as a normal completion.
        ST_WAIT: begin
          if (EFF_DONE) begin
            EFF_START <= 1'b0;
            state     <= ST_RELEASE;
          end else if (wait_cnt == WAIT_LAST) begin
            EFF_START   <= 1'b0;
            TIMEOUT_ERR <= 1'b1;
            state       <= ST_RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        // Hold here until the effect drops DONE so the next START is clean.
        ST_RELEASE: begin
          if (!EFF_DONE) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= ST_DRAIN;
            end else begin
              idx   <= next_idx;
              state <= ST_ISSUE;
            end
          end
        end

        // First DRAIN cycle loads sample 0; afterwards each handshake loads
        // the next sample, so OUT_SAMPLE only changes on an accepted beat.
        ST_DRAIN: begin
          if (!OUT_VALID) begin
            OUT_VALID  <= 1'b1;
            OUT_SAMPLE <= frame_buf[idx];
          end else if (OUT_READY) begin
            if (idx == LAST_IDX) begin
              OUT_VALID  <= 1'b0;
              FRAME_DONE <= 1'b1;
              idx        <= '0;
              state      <= ST_FINISH;
            end else begin
              idx        <= next_idx;
              OUT_SAMPLE <= frame_buf[next_idx];
            end
          end
        end

        ST_FINISH: begin
          FRAME_DONE <= 1'b0;
          if (ENABLE) begin
            EFF_GAIN <= GAIN_SEL;
            idx      <= '0;
            IN_READY <= 1'b1;
            state    <= ST_FILL;
          end else begin
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pedal_frame_sequencer.sv
// tb_pedal_frame_sequencer
//
// Self-checking bench for pedal_frame_sequencer with FRAME_LEN=4.
// A behavioural overdrive effect (out = in * (gain + 2)) with random latency
// answers the START/DONE handshake; expected outputs come from a per-frame
// arithmetic reference (multiply, clamp, or pass-through on timeout) held in
// a queue and compared as the frame drains.

module tb_pedal_frame_sequencer;

  localparam int FRAME_LEN = 4;
  localparam int ADDR_W    = 2;
  localparam int EFF_W     = 18;
  localparam int TIMEOUT   = 15;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    enable = 1'b0;
  logic                    gain_sel = 1'b0;
  logic                    in_valid = 1'b0;
  logic signed [15:0]      in_sample = '0;
  logic                    in_ready;
  logic                    eff_start;
  logic                    eff_gain;
  logic signed [15:0]      eff_in;
  logic                    eff_done;
  logic signed [EFF_W-1:0] eff_out;
  logic                    out_valid;
  logic signed [15:0]      out_sample;
  logic                    out_ready = 1'b0;
  logic                    busy;
  logic                    frame_done;
  logic                    timeout_err;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] stim [FRAME_LEN];
  logic signed [15:0] exp_q [$];

  bit hang_en = 1'b0;
  int lat_max = 3;
  int eff_cnt;
  bit eff_hang;
  int issue_no;

  int last_longest_run = 0;
  logic busy_after;
  logic in_ready_after;

  pedal_frame_sequencer #(
    .FRAME_LEN(FRAME_LEN),
    .ADDR_W   (ADDR_W),
    .EFF_W    (EFF_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .ENABLE     (enable),
    .GAIN_SEL   (gain_sel),
    .IN_VALID   (in_valid),
    .IN_SAMPLE  (in_sample),
    .IN_READY   (in_ready),
    .EFF_START  (eff_start),
    .EFF_GAIN   (eff_gain),
    .EFF_IN     (eff_in),
    .EFF_DONE   (eff_done),
    .EFF_OUT    (eff_out),
    .OUT_VALID  (out_valid),
    .OUT_SAMPLE (out_sample),
    .OUT_READY  (out_ready),
    .BUSY       (busy),
    .FRAME_DONE (frame_done),
    .TIMEOUT_ERR(timeout_err)
  );

  always #5 clk = ~clk;

  // Overdrive effect: once START is seen, answer after a random latency,
  // hold DONE until START drops. When hanging, sample 2 of each frame never
  // gets DONE.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eff_done <= 1'b0;
      eff_out  <= '0;
      eff_cnt  <= -1;
      eff_hang <= 1'b0;
      issue_no <= 0;
    end else if (eff_start) begin
      if (!eff_done) begin
        if (eff_cnt < 0) begin
          eff_cnt  <= int'($urandom_range(lat_max, 0));
          eff_hang <= hang_en && ((issue_no % FRAME_LEN) == 2);
          issue_no <= issue_no + 1;
        end else if (eff_cnt > 0) begin
          eff_cnt <= eff_cnt - 1;
        end else if (!eff_hang) begin
          eff_done <= 1'b1;
          eff_out  <= EFF_W'(int'(eff_in) * (int'(eff_gain) + 2));
        end
      end
    end else begin
      eff_done <= 1'b0;
      eff_cnt  <= -1;
    end
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference: each output is the input times (gain+2) clamped to 16 bits,
  // except a timed-out sample which comes back as it went in.
  function automatic void pushExpected(input int gain, input int hang_idx);
    for (int i = 0; i < FRAME_LEN; i++) begin
      int v;
      v = int'(stim[i]) * (gain + 2);
      if (i == hang_idx) v = int'(stim[i]);
      else if (v > 32767) v = 32767;
      else if (v < -32768) v = -32768;
      exp_q.push_back(16'(v));
    end
  endfunction

  // Feed stim[] with random gaps; optionally flip GAIN_SEL or drop ENABLE
  // right after the first sample is accepted.
  task automatic applyStimulus(input bit flip_gain, input bit drop_enable);
    int  k = 0;
    int  budget = 0;
    bit  rdy;
    bit  v;
    while (k < FRAME_LEN && budget < 200) begin
      @(negedge clk);
      budget++;
      rdy = in_ready;
      v = ($urandom_range(2, 0) != 0);
      in_valid = v;
      in_sample = v ? stim[k] : 16'($urandom);
      if (rdy && v) begin
        k++;
        if (k == 1) begin
          if (flip_gain) gain_sel = ~gain_sel;
          if (drop_enable) enable = 1'b0;
        end
      end
    end
    checkOutput("fill_accepted", 32'(k), 32'(FRAME_LEN));
  endtask

  // Run processing and drain; ready_mode 0 = always ready, 1 = 1,0,0,1 pattern.
  task automatic drainFrame(input int ready_mode);
    int  got = 0;
    int  cyc = 0;
    int  done_seen = 0;
    int  ir_bad = 0;
    int  hold_bad = 0;
    int  run = 0;
    int  longest = 0;
    int  p;
    bit  stalled = 1'b0;
    logic signed [15:0] held = '0;
    logic signed [15:0] exp_s;
    while (done_seen == 0 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (eff_start) run++;
      else begin
        if (run > longest) longest = run;
        run = 0;
      end
      if (in_ready) ir_bad++;
      if (stalled && (!out_valid || out_sample !== held)) hold_bad++;
      if (frame_done) begin
        done_seen++;
        checkOutput("valid_low_at_done", 32'(out_valid), 32'(0));
        checkOutput("outputs_before_done", 32'(got), 32'(FRAME_LEN));
        in_valid = 1'b0;
      end else begin
        in_valid = 1'($urandom_range(1, 0));
        in_sample = 16'($urandom);
        p = (cyc - 1) % 4;
        out_ready = (ready_mode == 0) ? 1'b1 : ((p == 0) || (p == 3));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("extra_output", 32'(got + 1), 32'(FRAME_LEN));
          end else begin
            exp_s = exp_q.pop_front();
            checkOutput($sformatf("out_sample[%0d]", got), 32'(out_sample), 32'(exp_s));
          end
          got++;
          stalled = 1'b0;
        end else if (out_valid) begin
          stalled = 1'b1;
          held = out_sample;
        end else begin
          stalled = 1'b0;
        end
      end
    end
    if (run > longest) longest = run;
    last_longest_run = longest;
    checkOutput("frame_done_seen", 32'(done_seen), 32'(1));
    checkOutput("in_ready_outside_fill", 32'(ir_bad), 32'(0));
    checkOutput("stall_hold", 32'(hold_bad), 32'(0));
    checkOutput("no_lost_samples", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("frame_done_pulse", 32'(frame_done), 32'(0));
    busy_after = busy;
    in_ready_after = in_ready;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int gain;
    int rises;
    int cyc;
    bit prev;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'(0));
    checkOutput("rst_eff_start", 32'(eff_start), 32'(0));
    checkOutput("rst_eff_gain", 32'(eff_gain), 32'(0));
    checkOutput("rst_eff_in", 32'(eff_in), 32'(0));
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_out_sample", 32'(out_sample), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_frame_done", 32'(frame_done), 32'(0));
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'(0));

    $display("[TB] basic gain 0 frame");
    stim = '{16'sd100, -16'sd200, 16'sd300, 16'sd0};
    gain_sel = 1'b0;
    enable = 1'b1;
    pushExpected(0, -1);
    applyStimulus(1'b0, 1'b1);
    drainFrame(0);
    checkOutput("a_timeout_err", 32'(timeout_err), 32'(0));
    checkOutput("a_idle_after", 32'(busy_after), 32'(0));

    $display("[TB] saturation frame");
    stim = '{16'sd20000, -16'sd20000, 16'sd10922, -16'sd10923};
    gain_sel = 1'b1;
    enable = 1'b1;
    pushExpected(1, -1);
    applyStimulus(1'b0, 1'b1);
    drainFrame(0);
    checkOutput("b_timeout_err", 32'(timeout_err), 32'(0));

    $display("[TB] effect timeout on sample 2");
    for (int i = 0; i < FRAME_LEN; i++) stim[i] = 16'($urandom);
    gain = int'($urandom_range(1, 0));
    gain_sel = 1'(gain);
    hang_en = 1'b1;
    enable = 1'b1;
    pushExpected(gain, 2);
    applyStimulus(1'b0, 1'b1);
    drainFrame(0);
    hang_en = 1'b0;
    checkOutput("timeout_wait_cycles", 32'(last_longest_run), 32'(TIMEOUT));
    checkOutput("c_timeout_err", 32'(timeout_err), 32'(1));

    $display("[TB] random frames with stalled output");
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FRAME_LEN; i++) stim[i] = 16'($urandom);
      gain = int'($urandom_range(1, 0));
      gain_sel = 1'(gain);
      enable = 1'b1;
      pushExpected(gain, -1);
      applyStimulus(1'b0, 1'b1);
      drainFrame(1);
      checkOutput("timeout_err_sticky", 32'(timeout_err), 32'(1));
    end

    $display("[TB] reset during wait of sample 1");
    stim = '{16'sd1111, 16'sd2222, 16'sd3333, 16'sd4444};
    gain_sel = 1'b1;
    enable = 1'b1;
    applyStimulus(1'b0, 1'b1);
    rises = 0;
    cyc = 0;
    prev = 1'b0;
    while (rises < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      if (eff_start && !prev) rises++;
      prev = eff_start;
    end
    checkOutput("reached_wait_s1", 32'(rises), 32'(2));
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    checkOutput("mid_rst_eff_start", 32'(eff_start), 32'(0));
    checkOutput("mid_rst_busy", 32'(busy), 32'(0));
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'(0));
    checkOutput("mid_rst_eff_in", 32'(eff_in), 32'(0));
    checkOutput("mid_rst_eff_gain", 32'(eff_gain), 32'(0));
    checkOutput("mid_rst_out_sample", 32'(out_sample), 32'(0));
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("mid_rst_timeout_err", 32'(timeout_err), 32'(0));
    checkOutput("mid_rst_frame_done", 32'(frame_done), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_idle", 32'(busy), 32'(0));
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'(0));
    for (int i = 0; i < FRAME_LEN; i++) stim[i] = 16'($urandom);
    gain = int'($urandom_range(1, 0));
    gain_sel = 1'(gain);
    enable = 1'b1;
    pushExpected(gain, -1);
    applyStimulus(1'b0, 1'b1);
    drainFrame(1);

    $display("[TB] back-to-back frames with gain flip");
    for (int i = 0; i < FRAME_LEN; i++) stim[i] = 16'($urandom);
    gain_sel = 1'b0;
    enable = 1'b1;
    pushExpected(0, -1);
    applyStimulus(1'b1, 1'b0);
    drainFrame(1);
    checkOutput("b2b_busy_held", 32'(busy_after), 32'(1));
    checkOutput("b2b_fill_next", 32'(in_ready_after), 32'(1));
    for (int i = 0; i < FRAME_LEN; i++) stim[i] = 16'($urandom);
    pushExpected(1, -1);
    applyStimulus(1'b0, 1'b1);
    drainFrame(0);
    checkOutput("b2b_idle_after", 32'(busy_after), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pedal_frame_sequencer.md
Name: pedal_frame_sequencer

Overview:
Frame-level controller that sequences a single-sample START/DONE effect datapath, such as overdrive_effect, over a whole audio frame.
- Collects FRAME_LEN input samples into an internal buffer.
- Issues each sample to the effect with a full START/DONE handshake, then saturates the result back into the buffer.
- Streams the processed frame out with valid/ready.
- Sits between the ADC sample stream and the DAC/output path; latches the per-frame gain configuration for the effect.

Parameters:
FRAME_LEN, 1000, samples per frame (bench overrides to 4)
ADDR_W, 10, buffer index width; must satisfy 2^ADDR_W >= FRAME_LEN
EFF_W, 18, width of signed effect result before saturation
TIMEOUT, 15, max WAIT cycles for EFF_DONE before bypass

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
ENABLE  in  1  run frames; sampled only in IDLE and at frame end
GAIN_SEL  in  1  gain config; latched at each frame start
IN_VALID  in  1  input sample valid
IN_SAMPLE  in  16  signed input sample
IN_READY  out  1  high only in FILL
EFF_START  out  1  effect start, level-held until DONE seen
EFF_GAIN  out  1  latched gain to effect
EFF_IN  out  16  signed sample presented to effect
EFF_DONE  in  1  effect done
EFF_OUT  in  EFF_W  signed effect result
OUT_VALID  out  1  output sample valid
OUT_SAMPLE  out  16  signed processed sample
OUT_READY  in  1  downstream accept
BUSY  out  1  state != IDLE
FRAME_DONE  out  1  one-cycle pulse after last output handshake
TIMEOUT_ERR  out  1  sticky; set on any effect timeout, cleared only by reset

Behaviour:
Reset (RESET_N=0, async):
- State goes to IDLE; all outputs and counters are 0.
- Buffer contents are don't-care.
- Reset mid-frame abandons the frame; no FRAME_DONE.

IDLE:
- When ENABLE=1: latch GAIN_SEL into EFF_GAIN, clear idx, go to FILL.

FILL:
- IN_READY=1.
- Each IN_VALID&IN_READY cycle writes buf[idx] and increments idx.
- On accepting sample FRAME_LEN-1: idx<=0, go to ISSUE.

ISSUE (1 cycle):
- EFF_IN<=buf[idx], EFF_START<=1, wait counter<=0, go to WAIT.
- EFF_IN stays stable until the next ISSUE.

WAIT:
- EFF_START=1.
- If EFF_DONE=1: buf[idx]<=sat16(EFF_OUT), go to RELEASE.
- Else increment the wait counter. When it reaches TIMEOUT: buf[idx] keeps the original sample (bypass), set TIMEOUT_ERR, go to RELEASE.

RELEASE:
- EFF_START=0; remain until EFF_DONE=0.
- The effect clears DONE only after sampling START low, so at least 1 cycle is spent here.
- Then: if idx==FRAME_LEN-1, idx<=0 and go to DRAIN; else idx++ and go to ISSUE.

DRAIN:
- OUT_VALID=1 no later than 2 cycles after entry, with OUT_SAMPLE=buf[idx].
- OUT_SAMPLE must be stable while OUT_VALID&!OUT_READY.
- Each OUT_VALID&OUT_READY advances idx.
- After the last handshake: FRAME_DONE=1 for 1 cycle, OUT_VALID=0.
- Then if ENABLE=1, latch GAIN_SEL and go to FILL; else go to IDLE.

Saturation sat16:
- EFF_OUT > 32767 gives 32767.
- EFF_OUT < -32768 gives -32768.
- Otherwise the low 16 bits.
- Signed compare on the full EFF_W width.

Other rules:
- ENABLE falling mid-frame is ignored; the frame completes.
- GAIN_SEL changes mid-frame are ignored.
- With a 1-cycle-latency effect, per-sample processing takes 4 cycles: ISSUE, WAIT, WAIT(DONE), RELEASE.
- Simultaneous EFF_DONE and timeout expiry: DONE wins; no error is set.
- IN_VALID outside FILL is ignored; IN_SAMPLE is not written.

Test Plan:
- FRAME_LEN=4, GAIN_SEL=0, overdrive model (out=in*(gain+2), EFF_W=18), inputs 100, -200, 300, 0 -> outputs 200, -400, 600, 0; FRAME_DONE pulses once; TIMEOUT_ERR=0.
- Saturation, GAIN_SEL=1, inputs 20000, -20000, 10922, -10923 -> 32767, -32768, 32766, -32768.
- Effect model never raises DONE on sample 2 -> that sample passes through unchanged after exactly TIMEOUT WAIT cycles; TIMEOUT_ERR=1 and stays 1 across the next frame.
- OUT_READY toggled 1,0,0,1,... and IN_VALID gapped randomly -> no sample lost or duplicated; OUT_SAMPLE holds while stalled; IN_READY=0 outside FILL.
- RESET_N asserted low during WAIT of sample 1 -> all outputs 0 immediately; after release, IDLE; next frame processes correctly from index 0.
- ENABLE held 1 over 2 frames with GAIN_SEL flipped mid-frame 1 -> frame 1 uses the old gain, frame 2 the new; FILL re-entered the cycle after FRAME_DONE without visiting IDLE.
